// File: rtl/sistema_rtc.sv
// BCD real-time clock for the sistema Avalon fabric: hh:mm:ss with a tick-driven
// sub-counter, an hh:mm alarm and a level interrupt for second/alarm events.
module sistema_rtc #(
   parameter int TICKS_PER_SEC = 1000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   input  logic        tick,
   output logic [15:0] readdata,
   output logic        irq
);

   localparam logic [9:0] MS_LAST = 10'(TICKS_PER_SEC - 1);

   logic [6:0]  sec_r, min_r, alarm_min_r;
   logic [5:0]  hour_r, alarm_hour_r;
   logic [9:0]  mscnt_r;
   logic [3:0]  ctrl_r;
   logic        sec_event_r, alarm_event_r;

   logic        wr_s, time_wr_s, status_wr_s, advance_s, step_s;
   logic        sec_wrap_s, min_wrap_s, alarm_hit_s;
   logic [6:0]  sec_next_s, min_next_s, hour_inc_s;
   logic [5:0]  hour_next_s;
   logic        sec_ok_s, min_ok_s, hour_ok_s, alarm_ok_s;
   logic [15:0] rd_mux_s;
   logic        unused_bits_s;

   function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
      return (v[3:0] <= 4'd9) && (v <= max);
   endfunction

   function automatic logic [6:0] bcd_inc(input logic [6:0] v);
      if (v[3:0] == 4'd9) begin
         return {v[6:4] + 3'd1, 4'd0};
      end else begin
         return v + 7'd1;
      end
   endfunction

   assign unused_bits_s = ^{writedata[15:14], writedata[7]};

   // Bus decode, write validation and the advance qualifier.
   always_comb begin
      wr_s        = chipselect && !write_n;
      time_wr_s   = wr_s && (address >= 3'd2) && (address <= 3'd5);
      status_wr_s = wr_s && (address == 3'd0);
      advance_s   = ctrl_r[0] && tick && !time_wr_s;
      step_s      = advance_s && (mscnt_r >= MS_LAST);
      sec_ok_s    = bcd_ok({1'b0, writedata[6:0]}, 8'h59);
      min_ok_s    = sec_ok_s;
      hour_ok_s   = bcd_ok({2'b00, writedata[5:0]}, 8'h23);
      alarm_ok_s  = sec_ok_s && bcd_ok({2'b00, writedata[13:8]}, 8'h23);
   end

   // Carry chain producing the time after a second step, plus alarm compare.
   always_comb begin
      sec_wrap_s  = (sec_r == 7'h59);
      min_wrap_s  = (min_r == 7'h59);
      hour_inc_s  = bcd_inc({1'b0, hour_r});
      sec_next_s  = sec_wrap_s ? 7'h00 : bcd_inc(sec_r);
      min_next_s  = min_r;
      hour_next_s = hour_r;
      if (sec_wrap_s) begin
         min_next_s = min_wrap_s ? 7'h00 : bcd_inc(min_r);
         if (min_wrap_s) begin
            hour_next_s = (hour_r == 6'h23) ? 6'h00 : hour_inc_s[5:0];
         end else begin
            hour_next_s = hour_r;
         end
      end else begin
         min_next_s = min_r;
      end
      alarm_hit_s = ctrl_r[3] && sec_wrap_s &&
                    ({hour_next_s, min_next_s} == {alarm_hour_r, alarm_min_r});
   end

   // Read mux; unmapped addresses return zero.
   always_comb begin
      case (address)
         3'd0:    rd_mux_s = {13'd0, ctrl_r[0], alarm_event_r, sec_event_r};
         3'd1:    rd_mux_s = {12'd0, ctrl_r};
         3'd2:    rd_mux_s = {9'd0, sec_r};
         3'd3:    rd_mux_s = {9'd0, min_r};
         3'd4:    rd_mux_s = {10'd0, hour_r};
         3'd5:    rd_mux_s = {2'd0, alarm_hour_r, 1'b0, alarm_min_r};
         3'd6:    rd_mux_s = {6'd0, mscnt_r};
         default: rd_mux_s = 16'd0;
      endcase
   end

   // Time keeping, register writes, event flags and registered read data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sec_r         <= 7'd0;
         min_r         <= 7'd0;
         hour_r        <= 6'd0;
         alarm_min_r   <= 7'd0;
         alarm_hour_r  <= 6'd0;
         mscnt_r       <= 10'd0;
         ctrl_r        <= 4'd0;
         sec_event_r   <= 1'b0;
         alarm_event_r <= 1'b0;
         readdata      <= 16'd0;
      end else begin
         if (advance_s) begin
            if (mscnt_r < MS_LAST) begin
               mscnt_r <= mscnt_r + 10'd1;
            end else begin
               mscnt_r <= 10'd0;
               sec_r   <= sec_next_s;
               min_r   <= min_next_s;
               hour_r  <= hour_next_s;
            end
         end
         if (wr_s) begin
            case (address)
               3'd1: ctrl_r <= writedata[3:0];
               3'd2: if (sec_ok_s) begin
                  sec_r   <= writedata[6:0];
                  mscnt_r <= 10'd0;
               end
               3'd3: if (min_ok_s) min_r <= writedata[6:0];
               3'd4: if (hour_ok_s) hour_r <= writedata[5:0];
               3'd5: if (alarm_ok_s) begin
                  alarm_hour_r <= writedata[13:8];
                  alarm_min_r  <= writedata[6:0];
               end
               default: ;
            endcase
         end
         // A set wins over a same-cycle software clear.
         sec_event_r   <= step_s | (sec_event_r & ~(status_wr_s & writedata[0]));
         alarm_event_r <= (step_s & alarm_hit_s) |
                          (alarm_event_r & ~(status_wr_s & writedata[1]));
         readdata      <= rd_mux_s;
      end
   end

   assign irq = (sec_event_r & ctrl_r[1]) | (alarm_event_r & ctrl_r[2]);

endmodule

// File: tb/tb_sistema_rtc.sv
// Randomized and directed bench for sistema_rtc against a seconds-of-day reference model.
module tb_sistema_rtc;
   localparam int TPS = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = 3'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [15:0] writedata = 16'd0;
   logic        tick = 1'b0;
   logic [15:0] readdata;
   logic        irq;

   int total = 0;
   int bad = 0;
   logic [15:0] exp_rd;
   logic        exp_irq;

   // model state: time as seconds of day, alarm as plain integers
   int tod, ms, ah_m, am_m;
   bit [3:0] ctrl_m;
   bit sev_m, aev_m;

   sistema_rtc #(.TICKS_PER_SEC(TPS)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .tick(tick),
      .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   function automatic int bcd(int n);
      return ((n / 10) * 16) + (n % 10);
   endfunction

   function automatic bit bcd_valid(int v, int maxd);
      return ((v % 16) <= 9) && (((v / 16) * 10 + (v % 16)) <= maxd);
   endfunction

   function automatic int dec(int v);
      return (v / 16) * 10 + (v % 16);
   endfunction

   task automatic model_reset();
      tod = 0; ms = 0; ah_m = 0; am_m = 0; ctrl_m = 4'd0; sev_m = 1'b0; aev_m = 1'b0;
   endtask

   function automatic logic [15:0] model_read(int a);
      case (a)
         0: return {13'd0, ctrl_m[0], aev_m, sev_m};
         1: return {12'd0, ctrl_m};
         2: return 16'(bcd(tod % 60));
         3: return 16'(bcd((tod / 60) % 60));
         4: return 16'(bcd(tod / 3600));
         5: return 16'((bcd(ah_m) * 256) + bcd(am_m));
         6: return 16'(ms);
         default: return 16'd0;
      endcase
   endfunction

   task automatic model_step(bit cs, bit wn, int a, logic [15:0] wd, bit tk);
      bit wr, twr, adv, sset, aset;
      int v, v2;
      wr = cs && !wn;
      twr = wr && (a >= 2) && (a <= 5);
      adv = ctrl_m[0] && tk && !twr;
      sset = 1'b0; aset = 1'b0;
      if (adv) begin
         if (ms < TPS - 1) ms++;
         else begin
            ms = 0;
            tod = (tod + 1) % 86400;
            sset = 1'b1;
            if (ctrl_m[3] && (tod % 60 == 0) && (tod / 3600 == ah_m) && ((tod / 60) % 60 == am_m))
               aset = 1'b1;
         end
      end
      if (wr) begin
         case (a)
            0: begin if (wd[0]) sev_m = 1'b0; if (wd[1]) aev_m = 1'b0; end
            1: ctrl_m = wd[3:0];
            2: begin v = int'(wd[6:0]); if (bcd_valid(v, 59)) begin tod = tod - (tod % 60) + dec(v); ms = 0; end end
            3: begin v = int'(wd[6:0]); if (bcd_valid(v, 59)) tod = (tod / 3600) * 3600 + dec(v) * 60 + (tod % 60); end
            4: begin v = int'(wd[5:0]); if (bcd_valid(v, 23)) tod = dec(v) * 3600 + (tod % 3600); end
            5: begin
               v = int'(wd[13:8]); v2 = int'(wd[6:0]);
               if (bcd_valid(v, 23) && bcd_valid(v2, 59)) begin ah_m = dec(v); am_m = dec(v2); end
            end
            default: ;
         endcase
      end
      if (sset) sev_m = 1'b1;
      if (aset) aev_m = 1'b1;
   endtask

   task automatic cyc(bit cs, bit wn, logic [2:0] a, logic [15:0] wd, bit tk);
      chipselect = cs; write_n = wn; address = a; writedata = wd; tick = tk;
      exp_rd = model_read(int'(a));
      @(posedge clk);
      model_step(cs, wn, int'(a), wd, tk);
      #1;
      exp_irq = (sev_m & ctrl_m[1]) | (aev_m & ctrl_m[2]);
      chipselect = 1'b0; write_n = 1'b1; tick = 1'b0;
   endtask

   task automatic wr(logic [2:0] a, logic [15:0] d, bit tk = 1'b0);
      cyc(1'b1, 1'b0, a, d, tk);
   endtask

   task automatic rd(logic [2:0] a);
      cyc(1'b1, 1'b1, a, 16'd0, 1'b0);
   endtask

   task automatic ticks(int n);
      repeat (n) cyc(1'b0, 1'b1, 3'd0, 16'd0, 1'b1);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int a = 0; a < 8; a++) begin
         rd(3'(a));
         total++;
         if (readdata !== exp_rd) begin $display("FAIL reset_read a=%0d got=%h exp=%h", a, readdata, exp_rd); bad++; end
      end
      total++;
      if (irq !== 1'b0) begin $display("FAIL reset_irq got=%b exp=0", irq); bad++; end
   endtask

   task automatic test_basic();
      wr(3'd1, 16'h0003);
      ticks(4);
      rd(3'd2);
      total++;
      if (readdata !== 16'h0001 || readdata !== exp_rd) begin $display("FAIL basic_sec got=%h exp=%h", readdata, exp_rd); bad++; end
      rd(3'd6);
      total++;
      if (readdata !== exp_rd) begin $display("FAIL basic_mscnt got=%h exp=%h", readdata, exp_rd); bad++; end
      rd(3'd0);
      total++;
      if (readdata !== 16'h0005 || readdata !== exp_rd) begin $display("FAIL basic_status got=%h exp=%h", readdata, exp_rd); bad++; end
      total++;
      if (irq !== 1'b1) begin $display("FAIL basic_irq got=%b exp=1", irq); bad++; end
      wr(3'd0, 16'h0001);
      total++;
      if (irq !== exp_irq || irq !== 1'b0) begin $display("FAIL basic_irq_clear got=%b exp=%b", irq, exp_irq); bad++; end
   endtask

   task automatic test_rollover(logic [15:0] hh);
      wr(3'd1, 16'h0000);
      wr(3'd4, hh); wr(3'd3, 16'h0059); wr(3'd2, 16'h0059);
      wr(3'd1, 16'h0001);
      ticks(4);
      for (int a = 2; a <= 4; a++) begin
         rd(3'(a));
         total++;
         if (readdata !== exp_rd) begin $display("FAIL rollover hh=%h a=%0d got=%h exp=%h", hh, a, readdata, exp_rd); bad++; end
      end
   endtask

   task automatic test_alarm(bit en);
      wr(3'd1, 16'h0000);
      wr(3'd0, 16'h0003);
      wr(3'd5, 16'h0715);
      wr(3'd4, 16'h0007); wr(3'd3, 16'h0014); wr(3'd2, 16'h0059);
      wr(3'd1, en ? 16'h000D : 16'h0005);
      ticks(4);
      rd(3'd0);
      total++;
      if (readdata !== exp_rd || readdata[1] !== en) begin $display("FAIL alarm en=%0d status got=%h exp=%h", en, readdata, exp_rd); bad++; end
      total++;
      if (irq !== exp_irq) begin $display("FAIL alarm_irq en=%0d got=%b exp=%b", en, irq, exp_irq); bad++; end
   endtask

   task automatic test_invalid();
      wr(3'd1, 16'h0000);
      wr(3'd2, 16'h0025);
      wr(3'd2, 16'h005A);
      wr(3'd2, 16'h0060);
      rd(3'd2);
      total++;
      if (readdata !== 16'h0025 || readdata !== exp_rd) begin $display("FAIL invalid_sec got=%h exp=%h", readdata, exp_rd); bad++; end
      wr(3'd5, 16'h2400);
      rd(3'd5);
      total++;
      if (readdata !== exp_rd) begin $display("FAIL invalid_alarm got=%h exp=%h", readdata, exp_rd); bad++; end
      wr(3'd4, 16'h001A);
      rd(3'd4);
      total++;
      if (readdata !== exp_rd) begin $display("FAIL invalid_hour got=%h exp=%h", readdata, exp_rd); bad++; end
   endtask

   task automatic test_collisions();
      wr(3'd1, 16'h0001);
      ticks(2);
      wr(3'd2, 16'h0030, 1'b1);
      rd(3'd2);
      total++;
      if (readdata !== 16'h0030 || readdata !== exp_rd) begin $display("FAIL tick_sec_write sec got=%h exp=%h", readdata, exp_rd); bad++; end
      rd(3'd6);
      total++;
      if (readdata !== 16'h0000 || readdata !== exp_rd) begin $display("FAIL tick_sec_write mscnt got=%h exp=%h", readdata, exp_rd); bad++; end
      wr(3'd0, 16'h0003);
      ticks(3);
      cyc(1'b1, 1'b0, 3'd0, 16'h0001, 1'b1);
      rd(3'd0);
      total++;
      if (readdata !== exp_rd || readdata[0] !== 1'b1) begin $display("FAIL clear_vs_set status got=%h exp=%h", readdata, exp_rd); bad++; end
   endtask

   task automatic test_stop();
      wr(3'd1, 16'h0001);
      ticks(2);
      wr(3'd1, 16'h0000);
      ticks(10);
      for (int a = 2; a <= 6; a++) begin
         rd(3'(a));
         total++;
         if (readdata !== exp_rd) begin $display("FAIL stopped a=%0d got=%h exp=%h", a, readdata, exp_rd); bad++; end
      end
   endtask

   task automatic test_random();
      bit cs, wn, tk;
      logic [2:0] a;
      logic [15:0] wd;
      for (int i = 0; i < 600; i++) begin
         cs = ($urandom_range(0, 3) != 0);
         wn = ($urandom_range(0, 2) != 0);
         a  = 3'($urandom_range(0, 7));
         tk = ($urandom_range(0, 1) != 0);
         case (a)
            3'd1: wd = ($urandom_range(0, 3) != 0) ? 16'(($urandom_range(0, 15) | 1)) : 16'($urandom);
            3'd2, 3'd3: wd = ($urandom_range(0, 4) != 0) ? 16'(bcd($urandom_range(50, 59))) : 16'($urandom);
            3'd4: wd = ($urandom_range(0, 4) != 0) ? 16'(bcd($urandom_range(0, 23))) : 16'($urandom);
            3'd5: wd = 16'(bcd($urandom_range(0, 24)) * 256 + bcd($urandom_range(55, 60)));
            default: wd = 16'($urandom);
         endcase
         cyc(cs, wn, a, wd, tk);
         total++;
         if (readdata !== exp_rd) begin $display("FAIL random_read i=%0d a=%0d got=%h exp=%h", i, a, readdata, exp_rd); bad++; end
         total++;
         if (irq !== exp_irq) begin $display("FAIL random_irq i=%0d got=%b exp=%b", i, irq, exp_irq); bad++; end
      end
   endtask

   task automatic test_reset_mid();
      wr(3'd1, 16'h0003);
      wr(3'd2, 16'h0041);
      ticks(6);
      reset_n = 1'b0;
      model_reset();
      #2;
      total++;
      if (readdata !== 16'd0 || irq !== 1'b0) begin $display("FAIL async_reset rd=%h irq=%b exp=0", readdata, irq); bad++; end
      @(negedge clk);
      reset_n = 1'b1;
      for (int a = 0; a < 8; a++) begin
         rd(3'(a));
         total++;
         if (readdata !== exp_rd) begin $display("FAIL mid_reset_read a=%0d got=%h exp=%h", a, readdata, exp_rd); bad++; end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_rollover(16'h0023);
      test_rollover(16'h0009);
      test_alarm(1'b1);
      test_alarm(1'b0);
      test_invalid();
      test_collisions();
      test_stop();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
